// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA pipeline: 640x480 active-area timing origin,
// the 12-bit (4:4:4) colour palette and the sprite speed FSM state type.
// No ports.
// ---------------------------------------------------------------------------
package vga_pkg;

  // First active pixel / line as seen on display_controller hCount/vCount.
  localparam int H_START  = 144;
  localparam int V_START  = 35;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // 12-bit RGB colours, 4 bits per channel.
  localparam logic [11:0] BLACK      = 12'h000;
  localparam logic [11:0] BG         = 12'h015;
  localparam logic [11:0] RED        = 12'hF00;
  localparam logic [11:0] PINK       = 12'hF8B;
  localparam logic [11:0] GREY       = 12'h888;
  localparam logic [11:0] LIGHT_BLUE = 12'h8CF;
  localparam logic [11:0] TAN        = 12'hDB9;

  // Sprite speed FSM. Encodings are fixed so they stay compatible with
  // older blocks that compare against raw 2-bit values.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } speed_state_t;

endpackage

// File: rtl/sprite_axis_step.sv
// ---------------------------------------------------------------------------
// sprite_axis_step
// Combinational next-position logic for one axis of the sprite.
//   pos   in  10 : current position on this axis
//   inc   in   1 : button moving towards larger coordinates
//   dec   in   1 : button moving towards smaller coordinates
//   step  in  11 : step size for this tick
//   next  out 10 : position after the step, wrapped or clamped to [0, MAX]
// Both buttons pressed together cancel out and the position holds.
// ---------------------------------------------------------------------------
module sprite_axis_step #(
  parameter int MAX  = 624,
  parameter bit WRAP = 1'b1
) (
  input  logic [9:0]  pos,
  input  logic        inc,
  input  logic        dec,
  input  logic [10:0] step,
  output logic [9:0]  next
);

  localparam logic [10:0] MAX_W = 11'(MAX);
  localparam logic [9:0]  MAX_P = 10'(MAX);

  // Sum is kept at 11 bits so an overshoot past MAX is never lost to
  // truncation before the compare.
  logic [10:0] pos_w;
  logic [10:0] sum;
  logic [9:0]  diff;

  always_comb begin
    pos_w = {1'b0, pos};
    sum   = pos_w + step;
    diff  = pos - step[9:0];
    next  = pos;
    if (inc && !dec) begin
      if (sum > MAX_W) begin
        next = WRAP ? 10'd0 : MAX_P;
      end else begin
        next = sum[9:0];
      end
    end else if (dec && !inc) begin
      if (pos_w < step) begin
        next = WRAP ? MAX_P : 10'd0;
      end else begin
        next = diff;
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_motion_ctrl
// Moves a rectangular sprite once per frame tick from four direction buttons
// (diagonals, hold-to-accelerate, wrap or clamp at the edges) and renders it
// into the display_controller raster.
//   clk                      in   1 : pixel clock
//   rst                      in   1 : asynchronous active-high reset
//   tick                     in   1 : one-cycle movement strobe per frame
//   up, down, left, right    in   1 : synchronised direction buttons
//   bright                   in   1 : high inside the visible area
//   hCount, vCount           in  10 : raster counters
//   xpos, ypos               out 10 : sprite top-left, active-area coords
//   sprite_hit               out  1 : registered, pixel lies on the sprite
//   rgb                      out 12 : registered pixel colour
// ---------------------------------------------------------------------------
module sprite_motion_ctrl #(
  parameter int          H_START     = vga_pkg::H_START,
  parameter int          V_START     = vga_pkg::V_START,
  parameter int          H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int          V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int          SPR_W       = 16,
  parameter int          SPR_H       = 16,
  parameter int          STEP        = 2,
  parameter int          ACCEL_TICKS = 4,
  parameter bit          WRAP        = 1'b1,
  parameter int          X_INIT      = 320,
  parameter int          Y_INIT      = 240,
  parameter logic [11:0] SPR_COLOR   = vga_pkg::RED,
  parameter logic [11:0] BG_COLOR    = vga_pkg::BG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [9:0]  xpos,
  output logic [9:0]  ypos,
  output logic        sprite_hit,
  output logic [11:0] rgb
);

  import vga_pkg::*;

  localparam int XMAX  = H_ACTIVE - SPR_W;
  localparam int YMAX  = V_ACTIVE - SPR_H;
  localparam int CNT_W = $clog2(ACCEL_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(ACCEL_TICKS);
  localparam logic [10:0]      STEP_BASE = 11'(STEP);
  localparam logic [10:0]      STEP_FAST = 11'(2 * STEP);

  speed_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [9:0]       disp_x;
  logic [9:0]       disp_y;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic [10:0]      step;
  logic             active;

  // Opposing buttons cancel, so an axis only counts when exactly one of
  // its two buttons is pressed.
  assign active  = (right ^ left) | (down ^ up);
  // Speed comes from the state held before this tick.
  assign step    = (state == FAST) ? STEP_FAST : STEP_BASE;
  assign cnt_inc = (cnt < CNT_SAT) ? cnt + 1'b1 : cnt;

  sprite_axis_step #(.MAX(XMAX), .WRAP(WRAP)) u_step_x (
    .pos  (xpos),
    .inc  (right),
    .dec  (left),
    .step (step),
    .next (x_next)
  );

  sprite_axis_step #(.MAX(YMAX), .WRAP(WRAP)) u_step_y (
    .pos  (ypos),
    .inc  (down),
    .dec  (up),
    .step (step),
    .next (y_next)
  );

  // Position and speed FSM; everything here advances only on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xpos  <= 10'(X_INIT);
      ypos  <= 10'(Y_INIT);
      state <= IDLE;
      cnt   <= '0;
    end else if (tick) begin
      if (active) begin
        xpos <= x_next;
        ypos <= y_next;
        case (state)
          IDLE: begin
            state <= SLOW;
            cnt   <= CNT_W'(1);
          end
          SLOW: begin
            cnt <= cnt_inc;
            if (cnt_inc >= CNT_SAT) begin
              state <= FAST;
            end
          end
          FAST:    state <= FAST;
          default: state <= IDLE;
        endcase
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

  // Shadow copy taken once per frame at the raster origin. Non-blocking
  // assignment means a coincident tick is seen only in the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_x <= 10'(X_INIT);
      disp_y <= 10'(Y_INIT);
    end else if (hCount == 10'd0 && vCount == 10'd0) begin
      disp_x <= xpos;
      disp_y <= ypos;
    end
  end

  // Hit window compare done at 12 bits so H_START + disp + size cannot
  // overflow the raster counter width.
  logic [11:0] h_lo, h_hi, v_lo, v_hi;
  logic        hit;

  assign h_lo = 12'(H_START) + {2'b00, disp_x};
  assign h_hi = h_lo + 12'(SPR_W);
  assign v_lo = 12'(V_START) + {2'b00, disp_y};
  assign v_hi = v_lo + 12'(SPR_H);
  assign hit  = ({2'b00, hCount} >= h_lo) && ({2'b00, hCount} < h_hi) &&
                ({2'b00, vCount} >= v_lo) && ({2'b00, vCount} < v_hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb        <= BLACK;
      sprite_hit <= 1'b0;
    end else begin
      sprite_hit <= bright & hit;
      if (!bright) begin
        rgb <= BLACK;
      end else if (hit) begin
        rgb <= SPR_COLOR;
      end else begin
        rgb <= BG_COLOR;
      end
    end
  end

endmodule
